// File: rtl/dcache_port_arb_pkg.sv
// Shared definitions for the data-cache port arbiter: FSM state encoding,
// the address slice used for store/load hazard matching, and the
// write-buffer entry layout.
package dcache_port_arb_pkg;

  typedef enum logic [1:0] {
    DCARB_LOAD  = 2'd0,
    DCARB_DRAIN = 2'd1,
    DCARB_HOLD  = 2'd2
  } dcarb_state_e;

  // Hazards are tracked per 8-byte word: address bits [63:3].
  localparam int MATCH_MSB = 63;
  localparam int MATCH_LSB = 3;
  localparam logic [63:0] MATCH_MASK =
    {{(MATCH_MSB - MATCH_LSB + 1){1'b1}}, {MATCH_LSB{1'b0}}};

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } wb_entry_t;

  // True when both addresses fall in the same tracked word.
  function automatic logic addr_match(input logic [63:0] a, input logic [63:0] b);
    return ((a ^ b) & MATCH_MASK) == 64'd0;
  endfunction

endpackage

// File: rtl/dcarb_wbuf.sv
// Retired-store write buffer: circular FIFO (head/tail/count) plus a
// parallel address match that returns the youngest matching store,
// including stores being pushed in the same cycle.
module dcarb_wbuf
  import dcache_port_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push0,
  input  logic [63:0]      push_addr0,
  input  logic [63:0]      push_data0,
  input  logic             push1,
  input  logic [63:0]      push_addr1,
  input  logic [63:0]      push_data1,
  input  logic             pop,
  input  logic [63:0]      match_addr,
  output logic             hit,
  output logic [63:0]      hit_data,
  output logic [63:0]      head_addr,
  output logic [63:0]      head_data,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_p1;

  // Power-of-two depth makes the natural pointer wrap the modulo index.
  assign tail_p1 = tail + PTR_W'(1);

  // Pointer and occupancy update; push and pop in one cycle both apply.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PTR_W'(1);
      tail  <= tail + PTR_W'(push0) + PTR_W'(push1);
      count <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

  // Entry storage; older store goes to tail, younger to tail+1.
  always_ff @(posedge clock) begin
    // NOTE: the entry array is deliberately not reset; count masks stale entries.
    if (push0) mem[tail]    <= '{addr: push_addr0, data: push_data0};
    if (push1) mem[tail_p1] <= '{addr: push_addr1, data: push_data1};
  end

  assign head_addr = mem[head].addr;
  assign head_data = mem[head].data;

  // Youngest-wins match: scan oldest to youngest, then same-cycle pushes.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count && addr_match(mem[head + PTR_W'(i)].addr, match_addr)) begin
        hit      = 1'b1;
        hit_data = mem[head + PTR_W'(i)].data;
      end
    end
    if (push0 && addr_match(push_addr0, match_addr)) begin
      hit      = 1'b1;
      hit_data = push_data0;
    end
    if (push1 && addr_match(push_addr1, match_addr)) begin
      hit      = 1'b1;
      hit_data = push_data1;
    end
  end

endmodule

// File: rtl/dcache_port_arb.sv
// Data-cache port arbiter between LSQ loads and the retired-store write
// buffer. Loads normally own the port; the buffer drains opportunistically,
// above the high watermark, or while a load waits on a pending store.
// Optional feature macro: DCARB_FWD_EN -- matching loads are answered from
// the write buffer instead of waiting in HOLD.
module dcache_port_arb
  import dcache_port_arb_pkg::*;
#(
  parameter int WB_DEPTH = 8,
  parameter int WB_HI    = 6,
  parameter int WB_LO    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsq_rd_mem,
  input  logic [63:0] lsq_addr,
  input  logic [6:0]  lsq_pr_idx,
  input  logic [4:0]  lsq_ar_idx,
  input  logic [1:0]  rob_st_num,
  input  logic [63:0] rob_st_addr0,
  input  logic [63:0] rob_st_value0,
  input  logic [63:0] rob_st_addr1,
  input  logic [63:0] rob_st_value1,
  input  logic        dc_ready,
  output logic        Dcache_avail,
  output logic [1:0]  wb_avail,
  output logic        dc_valid,
  output logic        dc_wr,
  output logic [63:0] dc_addr,
  output logic [63:0] dc_data,
  output logic [6:0]  dc_pr_idx,
  output logic [4:0]  dc_ar_idx,
  output logic        fwd_valid,
  output logic [6:0]  fwd_pr_idx,
  output logic [4:0]  fwd_ar_idx,
  output logic [63:0] fwd_value
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef DCARB_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  dcarb_state_e     state, state_n;
  logic [CNT_W-1:0] count, count_next, free;
  logic             push0, push1;
  logic             hit;
  logic [63:0]      hit_data, head_addr, head_data, match_addr;
  logic [63:0]      hold_addr;
  logic [6:0]       hold_pr_idx;
  logic [4:0]       hold_ar_idx;
  logic             do_wr, do_ld_lsq, do_ld_hold, do_fwd, hold_load;

  // Free space comes from registered occupancy only; pushes beyond it drop.
  assign free       = CNT_W'(WB_DEPTH) - count;
  assign push0      = (rob_st_num != 2'd0) && (free != '0);
  assign push1      = rob_st_num[1] && (free >= CNT_W'(2));
  assign wb_avail   = (free >= CNT_W'(2)) ? 2'd2 : free[1:0];
  assign count_next = count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(do_wr);

  // A held load keeps comparing its own address until the hazard clears.
  assign match_addr = (state == DCARB_HOLD) ? hold_addr : lsq_addr;

  dcarb_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
    .clock      (clock),
    .reset      (reset),
    .push0      (push0),
    .push_addr0 (rob_st_addr0),
    .push_data0 (rob_st_value0),
    .push1      (push1),
    .push_addr1 (rob_st_addr1),
    .push_data1 (rob_st_value1),
    .pop        (do_wr),
    .match_addr (match_addr),
    .hit        (hit),
    .hit_data   (hit_data),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (count)
  );

  // Port grant: pick at most one of write, LSQ load, held load or forward.
  always_comb begin
    Dcache_avail = 1'b0;
    do_wr        = 1'b0;
    do_ld_lsq    = 1'b0;
    do_ld_hold   = 1'b0;
    do_fwd       = 1'b0;
    hold_load    = 1'b0;
    case (state)
      DCARB_LOAD: begin
        Dcache_avail = dc_ready;
        if (lsq_rd_mem && dc_ready) begin
          if (!hit)        do_ld_lsq = 1'b1;
          else if (FWD_ON) do_fwd    = 1'b1;
          else             hold_load = 1'b1;
        end else if (!lsq_rd_mem && dc_ready && count != '0) begin
          do_wr = 1'b1;
        end
      end
      DCARB_DRAIN: begin
        do_wr = dc_ready && (count != '0);
      end
      DCARB_HOLD: begin
        if (hit) do_wr      = dc_ready && (count != '0);
        else     do_ld_hold = dc_ready;
      end
      default: ;
    endcase
  end

  // Cache request and forward outputs driven from the grant decision.
  always_comb begin
    dc_valid   = do_wr | do_ld_lsq | do_ld_hold;
    dc_wr      = do_wr;
    dc_addr    = '0;
    dc_data    = '0;
    dc_pr_idx  = '0;
    dc_ar_idx  = '0;
    if (do_wr) begin
      dc_addr = head_addr;
      dc_data = head_data;
    end else if (do_ld_lsq) begin
      dc_addr   = lsq_addr;
      dc_pr_idx = lsq_pr_idx;
      dc_ar_idx = lsq_ar_idx;
    end else if (do_ld_hold) begin
      dc_addr   = hold_addr;
      dc_pr_idx = hold_pr_idx;
      dc_ar_idx = hold_ar_idx;
    end
    fwd_valid  = do_fwd;
    fwd_value  = do_fwd ? hit_data   : '0;
    fwd_pr_idx = do_fwd ? lsq_pr_idx : '0;
    fwd_ar_idx = do_fwd ? lsq_ar_idx : '0;
  end

  // Next state from watermarks (on post-update count) and hazard status.
  always_comb begin
    state_n = state;
    case (state)
      DCARB_LOAD: begin
        if (hold_load)                        state_n = DCARB_HOLD;
        else if (count_next >= CNT_W'(WB_HI)) state_n = DCARB_DRAIN;
      end
      DCARB_DRAIN: begin
        if (count_next <= CNT_W'(WB_LO)) state_n = DCARB_LOAD;
      end
      DCARB_HOLD: begin
        if (do_ld_hold)
          state_n = (count_next >= CNT_W'(WB_HI)) ? DCARB_DRAIN : DCARB_LOAD;
      end
      default: state_n = DCARB_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= DCARB_LOAD;
    else        state <= state_n;
  end

  // Hold register captures a hazarded load; reset discards it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_addr   <= '0;
      hold_pr_idx <= '0;
      hold_ar_idx <= '0;
    end else if (hold_load) begin
      hold_addr   <= lsq_addr;
      hold_pr_idx <= lsq_pr_idx;
      hold_ar_idx <= lsq_ar_idx;
    end
  end

  // Protocol checks on the LSQ and ROB handshakes.
  a_load_only_when_avail: assert property (@(posedge clock) disable iff (!reset)
    !(lsq_rd_mem && !Dcache_avail));
  a_push_fits: assert property (@(posedge clock) disable iff (!reset)
    !(((rob_st_num != 2'd0) && (free == '0)) || (rob_st_num[1] && (free < CNT_W'(2)))));

endmodule

// File: tb/tb_dcache_port_arb.sv
// Self-checking bench for dcache_port_arb: a table of per-cycle vectors
// with hand-computed outputs, plus hand-written sequences for forwarding
// (DCARB_FWD_EN builds), reset while busy, and full/wrap-around draining.
module tb_dcache_port_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        lsq_rd_mem;
  logic [63:0] lsq_addr;
  logic [6:0]  lsq_pr_idx;
  logic [4:0]  lsq_ar_idx;
  logic [1:0]  rob_st_num;
  logic [63:0] rob_st_addr0, rob_st_value0, rob_st_addr1, rob_st_value1;
  logic        dc_ready;
  logic        Dcache_avail;
  logic [1:0]  wb_avail;
  logic        dc_valid, dc_wr;
  logic [63:0] dc_addr, dc_data;
  logic [6:0]  dc_pr_idx;
  logic [4:0]  dc_ar_idx;
  logic        fwd_valid;
  logic [6:0]  fwd_pr_idx;
  logic [4:0]  fwd_ar_idx;
  logic [63:0] fwd_value;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  dcache_port_arb #(.WB_DEPTH(8), .WB_HI(6), .WB_LO(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .lsq_rd_mem    (lsq_rd_mem),
    .lsq_addr      (lsq_addr),
    .lsq_pr_idx    (lsq_pr_idx),
    .lsq_ar_idx    (lsq_ar_idx),
    .rob_st_num    (rob_st_num),
    .rob_st_addr0  (rob_st_addr0),
    .rob_st_value0 (rob_st_value0),
    .rob_st_addr1  (rob_st_addr1),
    .rob_st_value1 (rob_st_value1),
    .dc_ready      (dc_ready),
    .Dcache_avail  (Dcache_avail),
    .wb_avail      (wb_avail),
    .dc_valid      (dc_valid),
    .dc_wr         (dc_wr),
    .dc_addr       (dc_addr),
    .dc_data       (dc_data),
    .dc_pr_idx     (dc_pr_idx),
    .dc_ar_idx     (dc_ar_idx),
    .fwd_valid     (fwd_valid),
    .fwd_pr_idx    (fwd_pr_idx),
    .fwd_ar_idx    (fwd_ar_idx),
    .fwd_value     (fwd_value)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic [63:0] addr;
    logic [6:0]  pr;
    logic [4:0]  ar;
    logic [1:0]  stn;
    logic [63:0] a0, v0, a1, v1;
    logic        rdy;
    logic        e_avail;
    logic [1:0]  e_wba;
    logic        e_val, e_wr;
    logic [63:0] e_addr, e_data;
    logic [6:0]  e_pr;
    logic [4:0]  e_ar;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic rd, logic [63:0] addr, logic [6:0] pr,
                              logic [4:0] ar, logic [1:0] stn, logic [63:0] a0,
                              logic [63:0] v0, logic [63:0] a1, logic [63:0] v1,
                              logic rdy, logic e_avail, logic [1:0] e_wba, logic e_val,
                              logic e_wr, logic [63:0] e_addr, logic [63:0] e_data,
                              logic [6:0] e_pr, logic [4:0] e_ar);
    vec_t v;
    v.name = n; v.rd = rd; v.addr = addr; v.pr = pr; v.ar = ar; v.stn = stn;
    v.a0 = a0; v.v0 = v0; v.a1 = a1; v.v1 = v1; v.rdy = rdy;
    v.e_avail = e_avail; v.e_wba = e_wba; v.e_val = e_val; v.e_wr = e_wr;
    v.e_addr = e_addr; v.e_data = e_data; v.e_pr = e_pr; v.e_ar = e_ar;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [63:0] addr, input logic [6:0] pr,
                       input logic [4:0] ar, input logic [1:0] stn,
                       input logic [63:0] a0, input logic [63:0] v0,
                       input logic [63:0] a1, input logic [63:0] v1, input logic rdy);
    lsq_rd_mem = rd; lsq_addr = addr; lsq_pr_idx = pr; lsq_ar_idx = ar;
    rob_st_num = stn; rob_st_addr0 = a0; rob_st_value0 = v0;
    rob_st_addr1 = a1; rob_st_value1 = v1; dc_ready = rdy;
  endtask

  // Apply one vector, compare combinational outputs mid-cycle, then clock it.
  task automatic apply_vec(input vec_t v);
    drive(v.rd, v.addr, v.pr, v.ar, v.stn, v.a0, v.v0, v.a1, v.v1, v.rdy);
    #1;
    check({v.name, ".Dcache_avail"}, 64'(Dcache_avail), 64'(v.e_avail));
    check({v.name, ".wb_avail"},     64'(wb_avail),     64'(v.e_wba));
    check({v.name, ".dc_valid"},     64'(dc_valid),     64'(v.e_val));
    check({v.name, ".dc_wr"},        64'(dc_wr),        64'(v.e_wr));
    check({v.name, ".dc_addr"},      dc_addr,           v.e_addr);
    check({v.name, ".dc_data"},      dc_data,           v.e_data);
    check({v.name, ".dc_pr_idx"},    64'(dc_pr_idx),    64'(v.e_pr));
    check({v.name, ".dc_ar_idx"},    64'(dc_ar_idx),    64'(v.e_ar));
    check({v.name, ".fwd_valid"},    64'(fwd_valid),    64'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [127:0] sb[$];
    int           cnt_m, seq, np;
    logic         rdy;
    logic [1:0]   exp_wba;
    logic         exp_val;

    // Idle, pass-through load, watermark drain.
    tbl.push_back(mk("idle",     0, 0,       0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ld_pass",  1, 64'h100, 12, 3, 0, 0, 0, 0, 0, 1,  1, 2, 1, 0, 64'h100, 0, 12, 3));
    tbl.push_back(mk("st01",     0, 0, 0, 0, 2, 64'h1000, 64'hA0, 64'h1008, 64'hA1, 0,  0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("st23",     0, 0, 0, 0, 2, 64'h1010, 64'hA2, 64'h1018, 64'hA3, 0,  0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("st45",     0, 0, 0, 0, 2, 64'h1020, 64'hA4, 64'h1028, 64'hA5, 0,  0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("drain_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("drain_w0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 1, 1, 64'h1000, 64'hA0, 0, 0));
    tbl.push_back(mk("drain_w1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 1, 1, 64'h1008, 64'hA1, 0, 0));
    tbl.push_back(mk("drain_w2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 1, 1, 64'h1010, 64'hA2, 0, 0));
    tbl.push_back(mk("drain_w3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 1, 1, 64'h1018, 64'hA3, 0, 0));
    tbl.push_back(mk("opp_w4",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 1, 1, 64'h1020, 64'hA4, 0, 0));
    tbl.push_back(mk("opp_w5",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 1, 1, 64'h1028, 64'hA5, 0, 0));
    tbl.push_back(mk("idle2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 0, 0, 0, 0, 0, 0));
`ifndef DCARB_FWD_EN
    // Hazard hold: 0x300 older, 0x200 younger; load to 0x204 hits 0x200.
    tbl.push_back(mk("hz_push",  0, 0, 0, 0, 2, 64'h300, 64'h33, 64'h200, 64'h22, 0,  0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("hz_load",  1, 64'h204, 7, 9, 0, 0, 0, 0, 0, 1,  1, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("hz_w300",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 1, 1, 64'h300, 64'h33, 0, 0));
    tbl.push_back(mk("hz_w200",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 1, 1, 64'h200, 64'h22, 0, 0));
    tbl.push_back(mk("hz_issue", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 1, 0, 64'h204, 0, 7, 9));
    tbl.push_back(mk("hz_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 0, 0, 0, 0, 0, 0));
`endif

    // Reset for two cycles with idle inputs.
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    foreach (tbl[i]) apply_vec(tbl[i]);

`ifdef DCARB_FWD_EN
    // Forwarding: two stores to 0x200, the younger (9) must be forwarded.
    drive(0, 0, 0, 0, 2, 64'h200, 64'd5, 64'h200, 64'd9, 0);
    @(posedge clock); #1;
    drive(1, 64'h200, 20, 1, 0, 0, 0, 0, 0, 1);
    #1;
    check("fwd.fwd_valid",  64'(fwd_valid),  64'd1);
    check("fwd.fwd_value",  fwd_value,       64'd9);
    check("fwd.fwd_pr_idx", 64'(fwd_pr_idx), 64'd20);
    check("fwd.fwd_ar_idx", 64'(fwd_ar_idx), 64'd1);
    check("fwd.dc_valid",   64'(dc_valid),   64'd0);
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("fwd.w5.dc_data", dc_data, 64'd5);
    @(posedge clock); #1;
    check("fwd.w9.dc_data", dc_data, 64'd9);
    @(posedge clock); #1;
`endif

    // Reset while a store is buffered (and, without forwarding, a load held).
    drive(0, 0, 0, 0, 1, 64'h500, 64'h55, 0, 0, 0);
    @(posedge clock); #1;
    drive(1, 64'h500, 1, 1, 0, 0, 0, 0, 0, 1);
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("rst.Dcache_avail", 64'(Dcache_avail), 64'd1);
    check("rst.wb_avail",     64'(wb_avail),     64'd2);
    check("rst.dc_valid",     64'(dc_valid),     64'd0);
    check("rst.fwd_valid",    64'(fwd_valid),    64'd0);
    @(posedge clock); #1;

    // Full and wrap-around: push 2 while popping 1, then fill, then drain.
    cnt_m = 0;
    seq   = 0;
    for (int k = 0; k < 18; k++) begin
      np  = (k < 6) ? 2 : ((k == 6) ? 1 : 0);
      rdy = (k != 6);
      drive(0, 0, 0, 0, 2'(np), 64'h4000 + 64'(seq * 8), 64'hD000 + 64'(seq),
            64'h4000 + 64'((seq + 1) * 8), 64'hD000 + 64'(seq + 1), rdy);
      #1;
      exp_wba = (8 - cnt_m >= 2) ? 2'd2 : 2'(8 - cnt_m);
      exp_val = rdy && (cnt_m > 0);
      check($sformatf("wrap%0d.wb_avail", k), 64'(wb_avail), 64'(exp_wba));
      check($sformatf("wrap%0d.dc_valid", k), 64'(dc_valid), 64'(exp_val));
      if (exp_val) begin
        check($sformatf("wrap%0d.dc_wr", k),   64'(dc_wr), 64'd1);
        check($sformatf("wrap%0d.dc_addr", k), dc_addr, sb[0][127:64]);
        check($sformatf("wrap%0d.dc_data", k), dc_data, sb[0][63:0]);
        void'(sb.pop_front());
      end
      for (int j = 0; j < np; j++)
        sb.push_back({64'h4000 + 64'((seq + j) * 8), 64'hD000 + 64'(seq + j)});
      seq   += np;
      cnt_m += np - int'(exp_val);
      @(posedge clock); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
